// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and RAM port that meet at mem_arbiter.
// Requests: a port raises x_req with its address (and store data/enables) and holds them unchanged
// until x_gnt is high in the same cycle; exactly one cycle after that grant x_rvalid pulses with
// x_rdata/x_err. There is no response back-pressure: every granted request yields exactly one response.
interface mem_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wen;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wen;
  logic [31:0]       ram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_wen, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output ram_addr, ram_wdata, ram_wen
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_wen, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  ram_addr, ram_wdata, ram_wen
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting instruction fetch and load/store share one single-port,
// one-cycle-latency RAM, with word-address range checking and registered responses.
module mem_arbiter #(
  parameter int ADDR_W = 22,
  parameter int WORDS  = 256
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  logic last;
  logic pend_i;
  logic pend_d;
  logic pend_err;

  logic i_oor;
  logic d_oor;
  logic i_gnt;
  logic d_gnt;
  logic gnt_err;

  assign i_oor = (bus.i_addr[31:2] >= 30'(WORDS));
  assign d_oor = (bus.d_addr[31:2] >= 30'(WORDS));

  // On contention the port that did not win last time goes first.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (bus.i_req && bus.d_req) begin
        if (last) i_gnt = 1'b1;
        else      d_gnt = 1'b1;
      end else begin
        i_gnt = bus.i_req;
        d_gnt = bus.d_req;
      end
    end
  end

  always_comb begin
    gnt_err = 1'b0;
    if (d_gnt)      gnt_err = d_oor;
    else if (i_gnt) gnt_err = i_oor;
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.ram_addr  = d_gnt ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
  assign bus.ram_wdata = bus.d_wdata;
  assign bus.ram_wen   = (d_gnt && !d_oor) ? bus.d_wen : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b0;
      pend_i   <= 1'b0;
      pend_d   <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      pend_i   <= i_gnt;
      pend_d   <= d_gnt;
      pend_err <= gnt_err;
      if (i_gnt)      last <= 1'b0;
      else if (d_gnt) last <= 1'b1;
    end
  end

  // A response still pending while reset is held is dropped rather than reported.
  assign bus.i_rvalid = pend_i && !rst;
  assign bus.d_rvalid = pend_d && !rst;
  assign bus.i_err    = bus.i_rvalid && pend_err;
  assign bus.d_err    = bus.d_rvalid && pend_err;
  assign bus.i_rdata  = (bus.i_rvalid && !pend_err) ? bus.ram_rdata : 32'h0;
  assign bus.d_rdata  = (bus.d_rvalid && !pend_err) ? bus.ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small byte-enable RAM model, a per-cycle vector table
// and hand-written sequences for reset-while-pending and final memory contents.
module tb_mem_arbiter;

  localparam int ADDR_W = 22;
  localparam int WORDS  = 256;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model (read-before-write, byte enables) ----------------
  logic [31:0] mem [0:WORDS-1];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr[7:0]];
  end

  // ---------------- scoreboard counters ----------------
  int total;
  int bad;

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wen;
    logic        e_i_gnt;
    logic        e_d_gnt;
    logic [31:0] e_ram_addr;
    logic [3:0]  e_ram_wen;
    logic        e_i_rvalid;
    logic [31:0] e_i_rdata;
    logic        e_i_err;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
    logic        e_d_err;
  } vec_t;

  vec_t vec [0:19];

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] we);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.d_wen   = we;
  endtask

  task automatic check_row(input vec_t v, input int r);
    chk("i_gnt",    r, 32'(bus.i_gnt),    32'(v.e_i_gnt));
    chk("d_gnt",    r, 32'(bus.d_gnt),    32'(v.e_d_gnt));
    chk("ram_addr", r, 32'(bus.ram_addr), v.e_ram_addr);
    chk("ram_wen",  r, 32'(bus.ram_wen),  32'(v.e_ram_wen));
    chk("i_rvalid", r, 32'(bus.i_rvalid), 32'(v.e_i_rvalid));
    chk("i_rdata",  r, bus.i_rdata,       v.e_i_rdata);
    chk("i_err",    r, 32'(bus.i_err),    32'(v.e_i_err));
    chk("d_rvalid", r, 32'(bus.d_rvalid), 32'(v.e_d_rvalid));
    chk("d_rdata",  r, bus.d_rdata,       v.e_d_rdata);
    chk("d_err",    r, 32'(bus.d_err),    32'(v.e_d_err));
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk);
    #1;
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // ir  i_addr        dr  d_addr        d_wdata       wen    ig dg ram_addr      wen   irv i_rdata       ie  drv d_rdata       de
    // Contention from reset: D, I, D, I
    vec[0]  = '{1, 32'h8,    1, 32'hC,    32'h0,        4'h0,  0, 1, 32'd3,   4'h0, 0, 32'h0,        0, 0, 32'h0,        0};
    vec[1]  = '{1, 32'h8,    1, 32'hC,    32'h0,        4'h0,  1, 0, 32'd2,   4'h0, 0, 32'h0,        0, 1, 32'h0BADF00D, 0};
    vec[2]  = '{1, 32'h8,    1, 32'hC,    32'h0,        4'h0,  0, 1, 32'd3,   4'h0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    vec[3]  = '{1, 32'h8,    1, 32'hC,    32'h0,        4'h0,  1, 0, 32'd2,   4'h0, 0, 32'h0,        0, 1, 32'h0BADF00D, 0};
    // Idle (ram_addr follows I), then single fetch
    vec[4]  = '{0, 32'h8,    0, 32'hC,    32'h0,        4'h0,  0, 0, 32'd2,   4'h0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    vec[5]  = '{1, 32'h8,    0, 32'h0,    32'h0,        4'h0,  1, 0, 32'd2,   4'h0, 0, 32'h0,        0, 0, 32'h0,        0};
    vec[6]  = '{0, 32'h0,    0, 32'h0,    32'h0,        4'h0,  0, 0, 32'd0,   4'h0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    // Store word 0 then fetch word 0: old data on ack, new data on fetch
    vec[7]  = '{0, 32'h0,    1, 32'h0,    32'h00000001, 4'hF,  0, 1, 32'd0,   4'hF, 0, 32'h0,        0, 0, 32'h0,        0};
    vec[8]  = '{1, 32'h0,    0, 32'h0,    32'h0,        4'h0,  1, 0, 32'd0,   4'h0, 0, 32'h0,        0, 1, 32'hA5A5A5A5, 0};
    vec[9]  = '{0, 32'h0,    0, 32'h0,    32'h0,        4'h0,  0, 0, 32'd0,   4'h0, 1, 32'h00000001, 0, 0, 32'h0,        0};
    // Single-byte store to word 1, then load it back
    vec[10] = '{0, 32'h0,    1, 32'h4,    32'h0000AB00, 4'h2,  0, 1, 32'd1,   4'h2, 0, 32'h0,        0, 0, 32'h0,        0};
    vec[11] = '{0, 32'h0,    1, 32'h4,    32'h0,        4'h0,  0, 1, 32'd1,   4'h0, 0, 32'h0,        0, 1, 32'h11223344, 0};
    vec[12] = '{0, 32'h0,    0, 32'h0,    32'h0,        4'h0,  0, 0, 32'd0,   4'h0, 0, 32'h0,        0, 1, 32'h1122AB44, 0};
    // Out-of-range store (word 256 aliases word 0 in the RAM model if wen leaks)
    vec[13] = '{0, 32'h0,    1, 32'h400,  32'hFFFFFFFF, 4'hF,  0, 1, 32'd256, 4'h0, 0, 32'h0,        0, 0, 32'h0,        0};
    vec[14] = '{0, 32'h0,    0, 32'h0,    32'h0,        4'h0,  0, 0, 32'd0,   4'h0, 0, 32'h0,        0, 1, 32'h0,        1};
    // Out-of-range fetch under contention (last = D so I wins), then D
    vec[15] = '{1, 32'h1000, 1, 32'h8,    32'h0,        4'h0,  1, 0, 32'h400, 4'h0, 0, 32'h0,        0, 0, 32'h0,        0};
    vec[16] = '{0, 32'h0,    1, 32'h8,    32'h0,        4'h0,  0, 1, 32'd2,   4'h0, 1, 32'h0,        1, 0, 32'h0,        0};
    vec[17] = '{0, 32'h0,    0, 32'h0,    32'h0,        4'h0,  0, 0, 32'd0,   4'h0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0};
    // Last in-range word
    vec[18] = '{0, 32'h0,    1, 32'h3FC,  32'h12345678, 4'hF,  0, 1, 32'd255, 4'hF, 0, 32'h0,        0, 0, 32'h0,        0};
    vec[19] = '{0, 32'h0,    0, 32'h0,    32'h0,        4'h0,  0, 0, 32'd0,   4'h0, 0, 32'h0,        0, 1, 32'h55AA55AA, 0};

    // ---------------- reset + preload ----------------
    rst    = 1'b1;
    pre_we = 1'b0;
    pre_idx = 8'h0;
    pre_data = 32'h0;
    drive(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    preload(8'd0,   32'hA5A5A5A5);
    preload(8'd1,   32'h11223344);
    preload(8'd2,   32'hDEADBEEF);
    preload(8'd3,   32'h0BADF00D);
    preload(8'd255, 32'h55AA55AA);
    @(posedge clk);
    #1;
    pre_we = 1'b0;

    // Both ports requesting while reset is held: nothing granted or returned
    drive(1, 32'h8, 1, 32'hC, 32'h0, 4'hF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_i_gnt",    c, 32'(bus.i_gnt),    32'h0);
      chk("rst_d_gnt",    c, 32'(bus.d_gnt),    32'h0);
      chk("rst_ram_wen",  c, 32'(bus.ram_wen),  32'h0);
      chk("rst_i_rvalid", c, 32'(bus.i_rvalid), 32'h0);
      chk("rst_d_rvalid", c, 32'(bus.d_rvalid), 32'h0);
      chk("rst_i_rdata",  c, bus.i_rdata,       32'h0);
      chk("rst_d_rdata",  c, bus.d_rdata,       32'h0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // ---------------- table ----------------
    for (int r = 0; r < 20; r++) begin
      drive(vec[r].i_req, vec[r].i_addr, vec[r].d_req, vec[r].d_addr, vec[r].d_wdata, vec[r].d_wen);
      @(negedge clk);
      check_row(vec[r], r);
      @(posedge clk);
      #1;
    end

    // ---------------- reset while a response is pending ----------------
    drive(0, 32'h0, 1, 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    chk("pre_rst_d_gnt", 100, 32'(bus.d_gnt), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_drop_d_rvalid", 101, 32'(bus.d_rvalid), 32'h0);
    chk("rst_drop_d_rdata",  101, bus.d_rdata,       32'h0);
    chk("rst_drop_i_gnt",    101, 32'(bus.i_gnt),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 32'h0, 1, 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    chk("post_rst_d_gnt",    102, 32'(bus.d_gnt),    32'h1);
    chk("post_rst_i_gnt",    102, 32'(bus.i_gnt),    32'h0);
    chk("post_rst_d_rvalid", 102, 32'(bus.d_rvalid), 32'h0);
    chk("post_rst_i_rvalid", 102, 32'(bus.i_rvalid), 32'h0);
    @(posedge clk);
    #1;
    drive(1, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("post_rst_i_gnt2",   103, 32'(bus.i_gnt),    32'h1);
    chk("post_rst_d_rvalid2",103, 32'(bus.d_rvalid), 32'h1);
    chk("post_rst_d_rdata2", 103, bus.d_rdata,       32'h1122AB44);
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("post_rst_i_rvalid3", 104, 32'(bus.i_rvalid), 32'h1);
    chk("post_rst_i_rdata3",  104, bus.i_rdata,       32'h00000001);
    chk("post_rst_d_rvalid3", 104, 32'(bus.d_rvalid), 32'h0);

    // ---------------- final RAM contents ----------------
    @(posedge clk);
    #1;
    chk("mem0",   200, mem[0],   32'h00000001);
    chk("mem1",   201, mem[1],   32'h1122AB44);
    chk("mem2",   202, mem[2],   32'hDEADBEEF);
    chk("mem3",   203, mem[3],   32'h0BADF00D);
    chk("mem255", 204, mem[255], 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port, one-cycle-latency data RAM between the CPU instruction-fetch port and the CPU load/store port. Each cycle it grants at most one request using round-robin priority on contention. It converts byte addresses to word addresses, range-checks them, and returns read data with a registered valid one cycle after the grant. It sits between `cpu` and `ram`, so both fetch and data can live in one memory.

## Interface
- `ADDR_W`, 22: RAM word-address width.
- `WORDS`, 256: number of populated RAM words; word index >= WORDS is out of range.

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`
- `i_addr`  in  32  fetch byte address; bits [1:0] ignored
- `i_gnt`  out  1  fetch request accepted this cycle (combinational)
- `i_rvalid`  out  1  fetch response valid (registered)
- `i_rdata`  out  32  fetch read data, meaningful when `i_rvalid`
- `i_err`  out  1  fetch address was out of range, qualified by `i_rvalid`
- `d_req`  in  1  data request; held with address/data/enables until `d_gnt`
- `d_addr`  in  32  data byte address; bits [1:0] ignored
- `d_wdata`  in  32  store data, byte lanes aligned to word
- `d_wen`  in  4  byte write enables; 0 = load
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`  out  1/1/32/1  same meaning as the fetch port
- `ram_addr`  out  ADDR_W  word address to RAM
- `ram_wdata`  out  32  write data to RAM
- `ram_wen`  out  4  byte write enables to RAM
- `ram_rdata`  in  32  RAM read data, registered in RAM and valid the cycle after the address is sampled

## Operation
- **State:**
  - `last`: last granted port, 1 bit; 0 = I, 1 = D.
  - `pend_i`, `pend_d`: response pending next cycle.
  - `pend_err`: error flag for the pending response.
- **Grant logic (combinational, forced 0 while `rst`):**
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port that is not `last`.
  - No request: no grant.
  - `last` updates to the granted port on every grant. It holds when there is no grant.
- **RAM drive:** `ram_addr` = granted port's `addr[ADDR_W+1:2]`. `ram_wdata` = `d_wdata`. `ram_wen` = `d_wen` only when D is granted and in range, else 0. With no grant, `ram_addr` follows the I port and `ram_wen` = 0.
- **Range check:** a request is out of range when `addr[31:2]` >= WORDS. It is still granted. RAM write enables are suppressed, and the response carries err = 1 and rdata = 0.
- **Response:** `pend_x` <= `x_gnt`, and `pend_err` <= the range error of the granted request.
  - `x_rvalid` = `pend_x`.
  - `x_rdata` = `ram_rdata` when `pend_x` and not `pend_err`, else 0.
  - `x_err` = `pend_x & pend_err`.
  - Stores also produce exactly one `d_rvalid`, which acts as the write acknowledge. Its rdata is the old word contents (RAM reads before write).
- **Reset:** `last` <= 0, so the first contention grants D. `pend_i`/`pend_d`/`pend_err` <= 0. A response pending when `rst` rises is discarded, with no rvalid. A grant is never issued in a reset cycle.

## Timing
- Grant latency 0: `x_gnt` asserts in the same cycle as `x_req` when that port wins.
- Response latency 1: `x_rvalid` asserts exactly one cycle after `x_gnt`.
- Throughput: one access per cycle total. Under continuous dual requests, grants alternate D, I, D, I.
- Worst-case wait for a continuously requesting port is 1 cycle.
- Back-to-back dependent accesses:
  - A store granted at cycle N followed by a load of the same word granted at N+1 returns the new data.
  - Bytes with `d_wen` bit 0 keep their old value.
- Requester dropping `req` before `gnt` is illegal. The arbiter does not check for it and simply ignores the request.
- Outputs after reset:
  - `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `i_err`, `d_err` = 0.
  - `i_rdata`, `d_rdata` = 0.
  - `ram_wen` = 0.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `i_req`=`d_req`=1 -> gnts 0, `ram_wen`=0, no rvalid. Release `rst` with both still requesting -> D granted first cycle, I second.
- **Single fetch:** preload mem[2]=0xDEADBEEF, `i_req`=1, `i_addr`=0x8 -> `i_gnt`=1 and `ram_addr`=2 same cycle; next cycle `i_rvalid`=1, `i_rdata`=0xDEADBEEF, `i_err`=0.
- **Contention:** both ports request continuously for 4 cycles, from reset -> grants D, I, D, I; each rvalid exactly one cycle after its grant; never both rvalid in one cycle.
- **Store/load ordering:** D stores 0x00000001 to byte addr 0 with `d_wen`=4'hF, then I reads addr 0 the next cycle -> `d_rvalid` with old data, then `i_rdata`=0x00000001.
- **Byte write:** mem[1]=0x11223344; D stores 0x0000AB00 to addr 0x4 with `d_wen`=4'b0010 -> mem[1]=0x1122AB44.
- **Out of range:** `d_addr`=0x400 (WORDS=256), `d_wen`=4'hF -> `d_gnt`=1, `ram_wen`=0, next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0, all RAM words unchanged.
